// File: rtl/onewire_pkg.sv
// onewire_pkg
//   Shared definitions for the 1-Wire bit-slot engine:
//   - command encodings (CMD_RESET / CMD_WRITE0 / CMD_WRITE1 / CMD_READ)
//   - slot timing in microseconds, measured from slot start
//   - FSM state enum
//   - microsecond counter width and timing lookup helpers
package onewire_pkg;

    // 10 bits cover the longest slot (960 us) without wrapping.
    localparam int US_CNT_W = 10;

    typedef enum logic [1:0] {
        CMD_RESET  = 2'd0,
        CMD_WRITE0 = 2'd1,
        CMD_WRITE1 = 2'd2,
        CMD_READ   = 2'd3
    } onewire_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOW     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } onewire_state_t;

    // Slot timing, microseconds from slot start.
    localparam logic [US_CNT_W-1:0] T_RESET_LOW    = 10'd480;
    localparam logic [US_CNT_W-1:0] T_RESET_SAMPLE = 10'd550;
    localparam logic [US_CNT_W-1:0] T_RESET_TOTAL  = 10'd960;
    localparam logic [US_CNT_W-1:0] T_WRITE0_LOW   = 10'd60;
    localparam logic [US_CNT_W-1:0] T_WRITE1_LOW   = 10'd6;
    localparam logic [US_CNT_W-1:0] T_READ_LOW     = 10'd6;
    localparam logic [US_CNT_W-1:0] T_READ_SAMPLE  = 10'd15;
    localparam logic [US_CNT_W-1:0] T_SLOT_TOTAL   = 10'd70;

    // Length of the driven-low phase for a command.
    function automatic logic [US_CNT_W-1:0] t_low_us(input onewire_cmd_t c);
        case (c)
            CMD_RESET:  return T_RESET_LOW;
            CMD_WRITE0: return T_WRITE0_LOW;
            CMD_WRITE1: return T_WRITE1_LOW;
            default:    return T_READ_LOW;
        endcase
    endfunction

    // Sample point; only meaningful where has_sample() is true.
    function automatic logic [US_CNT_W-1:0] t_sample_us(input onewire_cmd_t c);
        case (c)
            CMD_RESET: return T_RESET_SAMPLE;
            CMD_READ:  return T_READ_SAMPLE;
            default:   return '0;
        endcase
    endfunction

    function automatic logic has_sample(input onewire_cmd_t c);
        return (c == CMD_RESET) || (c == CMD_READ);
    endfunction

    // Whole slot length, including recovery padding.
    function automatic logic [US_CNT_W-1:0] t_total_us(input onewire_cmd_t c);
        return (c == CMD_RESET) ? T_RESET_TOTAL : T_SLOT_TOTAL;
    endfunction

endpackage

// File: rtl/onewire_bit_engine_if.sv
// onewire_bit_engine_if
//   Command / response channel between a byte-level controller (master)
//   and the bit-slot engine (slave).
//   Signals:
//     cmd_valid, cmd  - slot request from the controller
//     cmd_ready       - engine idle
//     rsp_valid       - one-cycle pulse at end of slot
//     rsp_bit         - presence (RESET) or sampled bit (READ), 0 for writes
//     rsp_err         - RESET only: bus still low at end of slot
//     busy            - slot in progress
//
// Handshake: a command transfers on the rising clk edge where cmd_valid and
// cmd_ready are both high. The master must hold cmd_valid and cmd stable
// until that edge; cmd_valid while cmd_ready is low has no effect. There is
// no response back-pressure: rsp_valid is a single-cycle pulse and rsp_bit /
// rsp_err hold their values until the next response.
interface onewire_bit_engine_if;
    import onewire_pkg::*;

    logic         cmd_valid;
    onewire_cmd_t cmd;
    logic         cmd_ready;
    logic         rsp_valid;
    logic         rsp_bit;
    logic         rsp_err;
    logic         busy;

    modport master (
        output cmd_valid,
        output cmd,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_bit,
        input  rsp_err,
        input  busy
    );

    modport slave (
        input  cmd_valid,
        input  cmd,
        output cmd_ready,
        output rsp_valid,
        output rsp_bit,
        output rsp_err,
        output busy
    );

endinterface

// File: rtl/onewire_us_tick.sv
// onewire_us_tick
//   Microsecond timebase for the bit-slot engine.
//   A prescaler counts 0..US_DIV-1 and asserts tick in its last count; on
//   that edge the prescaler wraps and us_cnt advances by one.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     clr       - synchronous clear of prescaler and us_cnt (held while idle)
//     tick      - high in the final clock of each microsecond
//     us_cnt    - whole microseconds elapsed since the last clear
module onewire_us_tick
    import onewire_pkg::*;
#(
    parameter int US_DIV = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                tick,
    output logic [US_CNT_W-1:0] us_cnt
);

    localparam int            PW        = $clog2(US_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(US_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [US_CNT_W-1:0] CNT_ONE = US_CNT_W'(1);

    logic [PW-1:0] presc;

    assign tick = (presc == PRESC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc  <= '0;
            us_cnt <= '0;
        end else if (clr) begin
            presc  <= '0;
            us_cnt <= '0;
        end else if (tick) begin
            presc  <= '0;
            us_cnt <= us_cnt + CNT_ONE;
        end else begin
            presc  <= presc + PRESC_ONE;
        end
    end

endmodule

// File: rtl/onewire_bit_engine.sv
// onewire_bit_engine
//   Open-drain 1-Wire bit-slot master. Each accepted command runs one slot
//   (reset/presence, write-0, write-1 or read) and ends with a one-cycle
//   response pulse.
//   Ports:
//     clk, rst   - system clock, asynchronous active-high reset
//     bus        - command/response channel (slave side)
//     pin_o      - data to the IOBUF wrapper, always 0 (open drain)
//     pin_oe     - high = drive the line low; the wrapper handles any OEN
//                  inversion
//     pin_i      - asynchronous pad level from the IOBUF
//     state_dbg  - current FSM state
module onewire_bit_engine
    import onewire_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 24000000
) (
    input  logic                 clk,
    input  logic                 rst,
    onewire_bit_engine_if.slave  bus,
    output logic                 pin_o,
    output logic                 pin_oe,
    input  logic                 pin_i,
    output onewire_state_t       state_dbg
);

    localparam int US_DIV = CLK_FREQ_HZ / 1000000;
    localparam logic [US_CNT_W-1:0] CNT_ONE = US_CNT_W'(1);

    if (((CLK_FREQ_HZ % 1000000) != 0) || (US_DIV < 2)) begin : g_bad_clk
        $error("onewire_bit_engine: CLK_FREQ_HZ must be an integer multiple of 1 MHz and at least 2 MHz");
    end

    // ------------------------------------------------------------------
    // Input synchronizer. Resets to 1 (idle bus level) so a reset never
    // looks like a device pulling low.
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       sync_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pin_i};
        end
    end

    assign sync_i = sync_q[1];

    // ------------------------------------------------------------------
    // Timebase. Held clear while idle so the count starts from zero on the
    // acceptance edge and can never wrap within a slot.
    // ------------------------------------------------------------------
    logic                tick;
    logic [US_CNT_W-1:0] us_cnt;
    onewire_state_t      state_q;

    onewire_us_tick #(
        .US_DIV (US_DIV)
    ) u_us_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == ST_IDLE),
        .tick   (tick),
        .us_cnt (us_cnt)
    );

    // ------------------------------------------------------------------
    // FSM: registered state and outputs, next values computed below.
    // ------------------------------------------------------------------
    onewire_state_t state_n;
    onewire_cmd_t   cmd_q, cmd_n;
    logic           samp_q, samp_n;
    logic           pin_oe_q, pin_oe_n;
    logic           cmd_ready_q, cmd_ready_n;
    logic           busy_q, busy_n;
    logic           rsp_valid_q, rsp_valid_n;
    logic           rsp_bit_q, rsp_bit_n;
    logic           rsp_err_q, rsp_err_n;

    logic accept;
    logic at_low_end;
    logic at_sample;
    logic at_total;

    assign accept = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;

    // us_cnt reaches t on the edge where the count is t-1 and tick is high,
    // which is exactly t*US_DIV edges after acceptance.
    assign at_low_end = tick && (us_cnt == (t_low_us(cmd_q) - CNT_ONE));
    assign at_sample  = tick && has_sample(cmd_q)
                             && (us_cnt == (t_sample_us(cmd_q) - CNT_ONE));
    assign at_total   = tick && (us_cnt == (t_total_us(cmd_q) - CNT_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_RESET;
            samp_q      <= 1'b1;
            pin_oe_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            cmd_q       <= cmd_n;
            samp_q      <= samp_n;
            pin_oe_q    <= pin_oe_n;
            cmd_ready_q <= cmd_ready_n;
            busy_q      <= busy_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_bit_q   <= rsp_bit_n;
            rsp_err_q   <= rsp_err_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        cmd_n       = cmd_q;
        samp_n      = samp_q;
        pin_oe_n    = pin_oe_q;
        cmd_ready_n = cmd_ready_q;
        busy_n      = busy_q;
        rsp_valid_n = 1'b0;
        rsp_bit_n   = rsp_bit_q;
        rsp_err_n   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                // Ready comes up one edge after reset release and stays up
                // until a command is taken.
                cmd_ready_n = 1'b1;
                if (accept) begin
                    cmd_n       = bus.cmd;
                    samp_n      = 1'b1;
                    cmd_ready_n = 1'b0;
                    busy_n      = 1'b1;
                    pin_oe_n    = 1'b1;
                    state_n     = ST_LOW;
                end
            end

            ST_LOW: begin
                if (at_low_end) begin
                    pin_oe_n = 1'b0;
                    state_n  = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (at_sample) begin
                    samp_n = sync_i;
                end
                // The end-of-slot level is only needed for this one
                // response, so it feeds rsp_err directly instead of being
                // kept in its own register.
                if (at_total) begin
                    state_n     = ST_DONE;
                    rsp_valid_n = 1'b1;
                    case (cmd_q)
                        CMD_RESET: begin
                            rsp_bit_n = ~samp_q;
                            rsp_err_n = ~sync_i;
                        end
                        CMD_READ: begin
                            rsp_bit_n = samp_q;
                            rsp_err_n = 1'b0;
                        end
                        default: begin
                            rsp_bit_n = 1'b0;
                            rsp_err_n = 1'b0;
                        end
                    endcase
                end
            end

            ST_DONE: begin
                state_n     = ST_IDLE;
                cmd_ready_n = 1'b1;
                busy_n      = 1'b0;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_bit   = rsp_bit_q;
    assign bus.rsp_err   = rsp_err_q;

    assign pin_o     = 1'b0;
    assign pin_oe    = pin_oe_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_onewire_bit_engine.sv
// tb_onewire_bit_engine
//   Bench for onewire_bit_engine at 4 MHz (4 clocks per microsecond).
//   The 1-Wire line is modelled as a pull-up with the master's drive-low and
//   one device pulldown window given in microseconds from slot start.
//   Expected responses and timings come from the slot timing table and the
//   response rules, evaluated on that window.
module tb_onewire_bit_engine;
    import onewire_pkg::*;

    localparam int CLK_FREQ_HZ = 4000000;
    localparam int D           = 4;

    // ---------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------
    // DUT
    // ---------------------------------------------------------------
    logic           pin_o;
    logic           pin_oe;
    logic           pin_i;
    onewire_state_t state_dbg;

    onewire_bit_engine_if bus_if();

    onewire_bit_engine #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .pin_o     (pin_o),
        .pin_oe    (pin_oe),
        .pin_i     (pin_i),
        .state_dbg (state_dbg)
    );

    // ---------------------------------------------------------------
    // Bus model: pull-up, master drive-low, one device pulldown window
    // ---------------------------------------------------------------
    bit dev_on = 1'b0;
    int dev_ps = 0;
    int dev_pe = 0;
    int acc_e  = 0;      // clock edge number of the latest acceptance
    int k_rel;
    logic dev_lo;

    always_comb begin
        k_rel  = cyc - acc_e;
        dev_lo = dev_on && (cyc >= acc_e) && (k_rel >= dev_ps * D) && (k_rel < dev_pe * D);
    end

    assign pin_i = !(pin_oe || dev_lo);

    // ---------------------------------------------------------------
    // Checking and scoreboard
    // ---------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Timing table in microseconds, indexed by command code.
    int t_low_tab [4] = '{480, 60, 6, 6};
    int t_samp_tab[4] = '{550, 0, 0, 15};
    int t_tot_tab [4] = '{960, 70, 70, 70};

    // Expected entry: {rsp_bit, rsp_err, rsp delay in cycles, pin_oe cycles}
    logic [33:0] exp_q[$];

    function automatic logic line_low(input int t_us, input bit on, input int ps, input int pe);
        return on && (t_us >= ps) && (t_us < pe);
    endfunction

    function automatic logic [33:0] model(input onewire_cmd_t c, input bit on, input int ps, input int pe);
        logic b;
        logic e;
        int   ci;
        ci = int'(c);
        b  = 1'b0;
        e  = 1'b0;
        if (c == CMD_RESET) begin
            b = line_low(t_samp_tab[ci], on, ps, pe);
            e = line_low(t_tot_tab[ci], on, ps, pe);
        end else if (c == CMD_READ) begin
            b = !line_low(t_samp_tab[ci], on, ps, pe);
        end
        return {b, e, 16'(t_tot_tab[ci] * D), 16'(t_low_tab[ci] * D)};
    endfunction

    // ---------------------------------------------------------------
    // Monitor (samples on the falling edge)
    // ---------------------------------------------------------------
    int oe_cnt         = 0;
    int acc_count      = 0;
    int rsp_count      = 0;
    int pin_o_bad      = 0;
    int ready_busy_bad = 0;
    logic [33:0] mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (pin_o !== 1'b0) pin_o_bad++;
            if (bus_if.busy && bus_if.cmd_ready) ready_busy_bad++;
            if (pin_oe) oe_cnt++;
            if (bus_if.cmd_valid && bus_if.cmd_ready) begin
                acc_e  = cyc + 1;
                oe_cnt = 0;
                acc_count++;
            end
            if (bus_if.rsp_valid) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_bit",    32'(bus_if.rsp_bit), 32'(mon_e[33]));
                    check("rsp_err",    32'(bus_if.rsp_err), 32'(mon_e[32]));
                    check("rsp_delay",  32'(cyc - acc_e),    32'(mon_e[31:16]));
                    check("oe_cycles",  32'(oe_cnt),         32'(mon_e[15:0]));
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------
    task automatic wait_accept(output int edge_no, input int budget);
        edge_no = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_if.cmd_ready) begin
                edge_no = cyc + 1;
                break;
            end
        end
        if (edge_no < 0) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input onewire_cmd_t c, input bit on, input int ps, input int pe,
                         input bit push, output int edge_no);
        dev_on = on;
        dev_ps = ps;
        dev_pe = pe;
        if (push) exp_q.push_back(model(c, on, ps, pe));
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd       = c;
        wait_accept(edge_no, 20);
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_count >= target) break;
        end
        if (rsp_count < target) check("rsp_timeout", 32'(rsp_count), 32'(target));
        repeat (2) @(posedge clk);
    endtask

    task automatic run_slot(input onewire_cmd_t c, input bit on, input int ps, input int pe);
        int e;
        int n0;
        n0 = rsp_count;
        issue(c, on, ps, pe, 1'b1, e);
        wait_rsp(n0 + 1, t_tot_tab[int'(c)] * D + 20);
    endtask

    function automatic bit near_sample(input int x);
        return ((x > 12) && (x < 18)) || ((x > 547) && (x < 553)) || ((x > 957) && (x < 963));
    endfunction

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin
        int e1, e2, n0, a0, ready_seen, ps, pe;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd       = CMD_RESET;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check("rst_rsp_bit",   32'(bus_if.rsp_bit),   32'd0);
        check("rst_rsp_err",   32'(bus_if.rsp_err),   32'd0);
        check("rst_busy",      32'(bus_if.busy),      32'd0);
        check("rst_pin_oe",    32'(pin_oe),           32'd0);
        check("rst_pin_o",     32'(pin_o),            32'd0);
        check("rst_state",     32'(state_dbg),        32'(ST_IDLE));
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(bus_if.cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_edge", 32'(bus_if.cmd_ready), 32'd1);

        // 1. RESET with a presence pulse starting 15-60 us after release
        ps = 480 + $urandom_range(15, 60);
        pe = ps + $urandom_range(60, 240);
        run_slot(CMD_RESET, 1'b1, ps, pe);

        // 2. RESET with no device, then with the line held low throughout
        run_slot(CMD_RESET, 1'b0, 0, 0);
        run_slot(CMD_RESET, 1'b1, 0, 5000);

        // 3. WRITE1 then WRITE0 back to back with cmd_valid held high
        dev_on = 1'b0;
        exp_q.push_back(model(CMD_WRITE1, 1'b0, 0, 0));
        exp_q.push_back(model(CMD_WRITE0, 1'b0, 0, 0));
        n0 = rsp_count;
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd       = CMD_WRITE1;
        wait_accept(e1, 20);
        @(posedge clk); #1;
        bus_if.cmd = CMD_WRITE0;
        wait_accept(e2, 400);
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
        check("b2b_accept_gap", 32'(e2 - e1), 32'(70 * D + 2));
        wait_rsp(n0 + 2, 400);

        // 4. READ: device low until 30 us, then no pulldown
        run_slot(CMD_READ, 1'b1, 2, 30);
        run_slot(CMD_READ, 1'b0, 0, 0);

        // 5. Random command traffic during a busy RESET slot
        n0 = rsp_count;
        issue(CMD_RESET, 1'b0, 0, 0, 1'b1, e1);
        a0 = acc_count;
        ready_seen = 0;
        for (int i = 0; i < 3800; i++) begin
            @(posedge clk); #1;
            bus_if.cmd_valid = 1'($urandom_range(0, 1));
            bus_if.cmd       = onewire_cmd_t'($urandom_range(0, 3));
            if (bus_if.cmd_ready) ready_seen++;
        end
        bus_if.cmd_valid = 1'b0;
        wait_rsp(n0 + 1, 100);
        check("busy_no_accept", 32'(acc_count - a0), 32'd0);
        check("busy_ready_low", 32'(ready_seen),     32'd0);
        check("busy_one_rsp",   32'(rsp_count - n0), 32'd1);

        // 6. Asynchronous reset in the middle of WRITE0
        n0 = rsp_count;
        issue(CMD_WRITE0, 1'b0, 0, 0, 1'b0, e1);
        repeat (99) @(posedge clk);
        #1;
        check("oe_mid_write0", 32'(pin_oe), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("oe_async_release",   32'(pin_oe),           32'd0);
        check("busy_async_release", 32'(bus_if.busy),      32'd0);
        check("rsp_after_abort",    32'(bus_if.rsp_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_low_after_rst", 32'(bus_if.cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_high_after_rst", 32'(bus_if.cmd_ready), 32'd1);
        check("state_idle_after_rst", 32'(state_dbg),        32'(ST_IDLE));
        repeat (300) @(posedge clk);
        check("no_rsp_after_abort", 32'(rsp_count - n0), 32'd0);
        run_slot(CMD_READ, 1'b0, 0, 0);

        // Randomized slots with random pulldown windows kept clear of the
        // sample and end-of-slot points.
        for (int n = 0; n < 8; n++) begin
            onewire_cmd_t c;
            bit on;
            c  = onewire_cmd_t'($urandom_range(0, 3));
            on = 1'($urandom_range(0, 1));
            do begin
                ps = $urandom_range(0, 1000);
                pe = ps + $urandom_range(1, 600);
            end while (near_sample(ps) || near_sample(pe));
            run_slot(c, on, ps, pe);
        end

        check("pin_o_never_high",   32'(pin_o_bad),      32'd0);
        check("ready_while_busy",   32'(ready_busy_bad), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit
    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
